// File: rtl/hub75_bcm_scanner_pkg.sv
// Shared types and helpers for the HUB75 binary-coded-modulation scanner.
package hub75_bcm_scanner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_LATCH,
    ST_DISPLAY
  } scan_state_t;

  // Channel slot within a packed {R,G,B} pixel, multiplied by BPP to get the lsb
  localparam int CH_R = 2;
  localparam int CH_G = 1;
  localparam int CH_B = 0;

  // Counter widths never collapse to zero bits for degenerate parameter values
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/hub75_bcm_scanner_oe_timer.sv
// Output-enable timer: loaded with a bitplane index, runs down BASE_OE<<plane cycles.
module hub75_bcm_scanner_oe_timer
  import hub75_bcm_scanner_pkg::*;
#(
  parameter int BPP     = 4,
  parameter int BASE_OE = 64,
  localparam int PL_W   = clog2_min1(BPP),
  localparam int CNT_W  = $clog2(BASE_OE << (BPP - 1)) + 1
) (
  input  logic            clk_in,
  input  logic            rst,
  input  logic            load,
  input  logic            run,
  input  logic [PL_W-1:0] plane,
  output logic            expire
);

  logic [CNT_W-1:0] cnt;

  // Loaded one less than the on-time so expire marks the final enabled cycle
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'((BASE_OE << plane) - 1);
    end else if (run && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/hub75_bcm_scanner.sv
// HUB75 panel driver: shifts row pairs from a framebuffer and modulates OE_N per bitplane.
module hub75_bcm_scanner
  import hub75_bcm_scanner_pkg::*;
#(
  parameter int COLS      = 64,
  parameter int ROW_PAIRS = 32,
  parameter int BPP       = 4,
  parameter int BASE_OE   = 64,
  localparam int ADDR_W   = clog2_min1(ROW_PAIRS),
  localparam int COL_W    = clog2_min1(COLS),
  localparam int PIX_W    = 3 * BPP
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              en,
  output logic              pix_rd,
  output logic [ADDR_W-1:0] pix_row,
  output logic [COL_W-1:0]  pix_col,
  input  logic [PIX_W-1:0]  pix_top,
  input  logic [PIX_W-1:0]  pix_bot,
  output logic              R1_data,
  output logic              G1_data,
  output logic              B1_data,
  output logic              R2_data,
  output logic              G2_data,
  output logic              B2_data,
  output logic [ADDR_W-1:0] row_addr,
  output logic              clk_out,
  output logic              LAT,
  output logic              OE_N,
  output logic              done
);

  localparam int PL_W    = clog2_min1(BPP);
  localparam int SC_W    = $clog2(2 * COLS + 1);
  localparam int SC_LAST = 2 * COLS;

  scan_state_t       state, state_nxt;
  logic [SC_W-1:0]   sc;
  logic [ADDR_W-1:0] row;
  logic [PL_W-1:0]   plane;
  logic              oe_expire;
  logic              shift_end, last_plane, last_row;
  logic [BPP-1:0]    top_r, top_g, top_b, bot_r, bot_g, bot_b;

  assign shift_end  = (sc == SC_W'(SC_LAST));
  assign last_plane = (plane == PL_W'(BPP - 1));
  assign last_row   = (row == ADDR_W'(ROW_PAIRS - 1));

  assign top_r = pix_top[CH_R*BPP +: BPP];
  assign top_g = pix_top[CH_G*BPP +: BPP];
  assign top_b = pix_top[CH_B*BPP +: BPP];
  assign bot_r = pix_bot[CH_R*BPP +: BPP];
  assign bot_g = pix_bot[CH_G*BPP +: BPP];
  assign bot_b = pix_bot[CH_B*BPP +: BPP];

  assign pix_row = row;
  assign pix_col = sc[COL_W:1];

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Panel strobes decode straight from state so OE_N can never overlap LAT or shifting
  always_comb begin
    state_nxt = state;
    pix_rd    = 1'b0;
    clk_out   = 1'b0;
    LAT       = 1'b0;
    OE_N      = 1'b1;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        pix_rd  = ~sc[0] & ~shift_end;
        clk_out = ~sc[0] & (sc != '0);
        if (shift_end) state_nxt = ST_LATCH;
      end
      ST_LATCH: begin
        LAT       = 1'b1;
        state_nxt = ST_DISPLAY;
      end
      ST_DISPLAY: begin
        OE_N = 1'b0;
        if (oe_expire) begin
          if (!last_plane || !last_row) begin
            state_nxt = ST_SHIFT;
          end else begin
            done      = 1'b1;
            state_nxt = en ? ST_SHIFT : ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Shift phase counter is cleared outside SHIFT; it never wraps by itself
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sc       <= '0;
      row      <= '0;
      plane    <= '0;
      row_addr <= '0;
    end else begin
      if (state == ST_SHIFT && !shift_end) sc <= sc + 1'b1;
      else                                 sc <= '0;
      if (state == ST_LATCH) row_addr <= row;
      if (state == ST_DISPLAY && oe_expire) begin
        if (!last_plane) begin
          plane <= plane + 1'b1;
        end else begin
          plane <= '0;
          row   <= last_row ? '0 : row + 1'b1;
        end
      end
    end
  end

  // Read data arrives one cycle after pix_rd, i.e. on the odd shift phases
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      {R1_data, G1_data, B1_data, R2_data, G2_data, B2_data} <= 6'b0;
    end else if (state == ST_SHIFT && sc[0]) begin
      R1_data <= top_r[plane];
      G1_data <= top_g[plane];
      B1_data <= top_b[plane];
      R2_data <= bot_r[plane];
      G2_data <= bot_g[plane];
      B2_data <= bot_b[plane];
    end
  end

  hub75_bcm_scanner_oe_timer #(
    .BPP     (BPP),
    .BASE_OE (BASE_OE)
  ) u_oe_timer (
    .clk_in (clk_in),
    .rst    (rst),
    .load   (state == ST_LATCH),
    .run    (state == ST_DISPLAY),
    .plane  (plane),
    .expire (oe_expire)
  );

endmodule

// File: tb/tb_hub75_bcm_scanner.sv
// Directed bench for hub75_bcm_scanner on a 4x(2x2) panel with 2 bitplanes.
module tb_hub75_bcm_scanner;

  localparam int COLS      = 4;
  localparam int ROW_PAIRS = 2;
  localparam int BPP       = 2;
  localparam int BASE_OE   = 8;
  localparam int FRAME_LEN = 88;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       pix_rd;
  logic [0:0] pix_row;
  logic [1:0] pix_col;
  logic [5:0] pix_top = 6'h0;
  logic [5:0] pix_bot = 6'h0;
  logic       R1_data, G1_data, B1_data, R2_data, G2_data, B2_data;
  logic [0:0] row_addr;
  logic       clk_out, LAT, OE_N, done;

  logic [5:0] fb_top [ROW_PAIRS][COLS];
  logic [5:0] fb_bot [ROW_PAIRS][COLS];

  int errors = 0;
  int checks = 0;

  logic [5:0] rise_bits [32];
  int rise_cnt, oe_runs, lat_cnt, done_cyc, rd_cnt, ghost_cnt;
  int oe_len [8];
  int oe_row [8];

  hub75_bcm_scanner #(
    .COLS      (COLS),
    .ROW_PAIRS (ROW_PAIRS),
    .BPP       (BPP),
    .BASE_OE   (BASE_OE)
  ) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .en       (en),
    .pix_rd   (pix_rd),
    .pix_row  (pix_row),
    .pix_col  (pix_col),
    .pix_top  (pix_top),
    .pix_bot  (pix_bot),
    .R1_data  (R1_data),
    .G1_data  (G1_data),
    .B1_data  (B1_data),
    .R2_data  (R2_data),
    .G2_data  (G2_data),
    .B2_data  (B2_data),
    .row_addr (row_addr),
    .clk_out  (clk_out),
    .LAT      (LAT),
    .OE_N     (OE_N),
    .done     (done)
  );

  always #5 clk_in = ~clk_in;

  // Framebuffer RAM with one cycle of read latency
  always @(posedge clk_in) begin
    if (pix_rd) begin
      pix_top <= fb_top[pix_row][pix_col];
      pix_bot <= fb_bot[pix_row][pix_col];
    end
  end

  task automatic fill_fb(input logic [5:0] top, input logic [5:0] bot);
    for (int r = 0; r < ROW_PAIRS; r++)
      for (int c = 0; c < COLS; c++) begin
        fb_top[r][c] = top;
        fb_bot[r][c] = bot;
      end
  endtask

  task automatic restart();
    rst = 1'b1;
    en  = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    rst = 1'b0;
    @(negedge clk_in);
  endtask

  // Runs one frame from IDLE, recording panel activity; cycle 1 is the first pix_rd
  task automatic capture_frame(input int drop_at, input bit raise_on_done);
    int  c;
    int  run;
    int  cur_row;
    bit  started;
    bit  prev_clk;
    rise_cnt = 0; oe_runs = 0; lat_cnt = 0; done_cyc = 0; rd_cnt = 0; ghost_cnt = 0;
    c = 0; run = 0; cur_row = 0; started = 1'b0; prev_clk = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 400 && done_cyc == 0; i++) begin
      @(negedge clk_in);
      if (!started && pix_rd) started = 1'b1;
      if (started) begin
        c++;
        if (c == drop_at) en = 1'b0;
        if (clk_out && !prev_clk) begin
          if (rise_cnt < 32) rise_bits[rise_cnt] = {R1_data, G1_data, B1_data, R2_data, G2_data, B2_data};
          rise_cnt++;
        end
        if (!OE_N) begin
          run++;
          cur_row = int'(row_addr);
        end else if (run != 0) begin
          if (oe_runs < 8) begin oe_len[oe_runs] = run; oe_row[oe_runs] = cur_row; end
          oe_runs++;
          run = 0;
        end
        if (!OE_N && (LAT || clk_out)) ghost_cnt++;
        if (LAT) lat_cnt++;
        if (pix_rd) rd_cnt++;
        if (done) begin
          done_cyc = c;
          if (raise_on_done) en = 1'b1;
        end
        prev_clk = clk_out;
      end
    end
    if (run != 0) begin
      if (oe_runs < 8) begin oe_len[oe_runs] = run; oe_row[oe_runs] = cur_row; end
      oe_runs++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk_in);
    checks++;
    if (OE_N !== 1'b1) begin errors++; $display("[TB] FAIL reset_oe_n: got %b expected 1", OE_N); end
    checks++;
    if ({LAT, clk_out, done, pix_rd} !== 4'b0) begin
      errors++; $display("[TB] FAIL reset_strobes: got %b expected 0000", {LAT, clk_out, done, pix_rd});
    end
    checks++;
    if (row_addr !== 1'b0) begin errors++; $display("[TB] FAIL reset_row_addr: got %b expected 0", row_addr); end
    checks++;
    if ({R1_data, G1_data, B1_data, R2_data, G2_data, B2_data} !== 6'b0) begin
      errors++; $display("[TB] FAIL reset_data: got %b expected 000000", {R1_data, G1_data, B1_data, R2_data, G2_data, B2_data});
    end
  endtask

  task automatic test_reset_mid_display();
    bit found;
    fill_fb(6'h3F, 6'h00);
    restart();
    en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk_in);
      if (!OE_N && row_addr == 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("[TB] FAIL mid_display_reached: got 0 expected 1"); end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (OE_N !== 1'b1) begin errors++; $display("[TB] FAIL async_reset_oe_n: got %b expected 1", OE_N); end
    checks++;
    if (LAT !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_lat: got %b expected 0", LAT); end
    checks++;
    if (row_addr !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_row_addr: got %b expected 0", row_addr); end
    en = 1'b0;
    @(negedge clk_in);
    rst = 1'b0;
  endtask

  task automatic test_solid_frame();
    int exp_len [4] = '{8, 16, 8, 16};
    int exp_row [4] = '{0, 0, 1, 1};
    fill_fb(6'h3F, 6'h00);
    restart();
    capture_frame(0, 1'b0);
    en = 1'b0;
    checks++;
    if (rise_cnt != 16) begin errors++; $display("[TB] FAIL solid_rise_count: got %0d expected 16", rise_cnt); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rise_bits[i] !== 6'b111000) begin
        errors++; $display("[TB] FAIL solid_rise_%0d: got %b expected 111000", i, rise_bits[i]);
      end
    end
    checks++;
    if (rd_cnt != 16) begin errors++; $display("[TB] FAIL solid_pix_rd_count: got %0d expected 16", rd_cnt); end
    checks++;
    if (oe_runs != 4) begin errors++; $display("[TB] FAIL oe_run_count: got %0d expected 4", oe_runs); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (oe_len[i] != exp_len[i] || oe_row[i] != exp_row[i]) begin
        errors++;
        $display("[TB] FAIL oe_run_%0d: got len=%0d row=%0d expected len=%0d row=%0d",
                 i, oe_len[i], oe_row[i], exp_len[i], exp_row[i]);
      end
    end
    checks++;
    if (lat_cnt != 4) begin errors++; $display("[TB] FAIL lat_count: got %0d expected 4", lat_cnt); end
    checks++;
    if (done_cyc != FRAME_LEN) begin errors++; $display("[TB] FAIL done_cycle: got %0d expected %0d", done_cyc, FRAME_LEN); end
    checks++;
    if (ghost_cnt != 0) begin errors++; $display("[TB] FAIL ghosting: got %0d expected 0", ghost_cnt); end
  endtask

  task automatic test_bit_planes();
    logic [5:0] exp_bits [16];
    fill_fb(6'h00, 6'h00);
    fb_top[0][2] = 6'b10_01_00;
    fb_bot[1][1] = 6'b01_10_11;
    for (int i = 0; i < 16; i++) exp_bits[i] = 6'b0;
    exp_bits[2]  = 6'b010_000;
    exp_bits[6]  = 6'b100_000;
    exp_bits[9]  = 6'b000_101;
    exp_bits[13] = 6'b000_011;
    restart();
    capture_frame(0, 1'b0);
    en = 1'b0;
    checks++;
    if (rise_cnt != 16) begin errors++; $display("[TB] FAIL plane_rise_count: got %0d expected 16", rise_cnt); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rise_bits[i] !== exp_bits[i]) begin
        errors++; $display("[TB] FAIL plane_rise_%0d: got %b expected %b", i, rise_bits[i], exp_bits[i]);
      end
    end
  endtask

  task automatic test_en_drop();
    int stray;
    fill_fb(6'h3F, 6'h00);
    restart();
    capture_frame(30, 1'b0);
    checks++;
    if (done_cyc != FRAME_LEN) begin errors++; $display("[TB] FAIL drop_done_cycle: got %0d expected %0d", done_cyc, FRAME_LEN); end
    checks++;
    if (oe_runs != 4) begin errors++; $display("[TB] FAIL drop_oe_runs: got %0d expected 4", oe_runs); end
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      if (pix_rd || !OE_N || clk_out || LAT) stray++;
    end
    checks++;
    if (stray != 0) begin errors++; $display("[TB] FAIL idle_after_drop: got %0d active cycles expected 0", stray); end
    checks++;
    if ({R1_data, R2_data} !== 2'b10) begin errors++; $display("[TB] FAIL data_hold: got %b expected 10", {R1_data, R2_data}); end
  endtask

  task automatic test_back_to_back();
    fill_fb(6'h3F, 6'h00);
    restart();
    capture_frame(0, 1'b0);
    checks++;
    if (done_cyc != FRAME_LEN) begin errors++; $display("[TB] FAIL b2b_done_cycle: got %0d expected %0d", done_cyc, FRAME_LEN); end
    @(negedge clk_in);
    checks++;
    if ({pix_rd, pix_row, pix_col} !== 4'b1_0_00) begin
      errors++; $display("[TB] FAIL b2b_next_read: got %b expected 1000", {pix_rd, pix_row, pix_col});
    end
    restart();
    capture_frame(30, 1'b1);
    checks++;
    if (done_cyc != FRAME_LEN) begin errors++; $display("[TB] FAIL late_en_done_cycle: got %0d expected %0d", done_cyc, FRAME_LEN); end
    @(negedge clk_in);
    checks++;
    if (pix_rd !== 1'b1) begin errors++; $display("[TB] FAIL late_en_next_read: got %b expected 1", pix_rd); end
    en = 1'b0;
  endtask

  initial begin
    fill_fb(6'h00, 6'h00);
    $display("[TB] start");
    test_reset();
    test_reset_mid_display();
    test_solid_frame();
    test_bit_planes();
    test_en_drop();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
